// File: rtl/iro_seed_loader.sv
// Ring-oscillator seed loader: shifts a seed word out on bclk/bdat MSB first,
// runs the oscillator for a programmed number of cycles, then snapshots its phases.
module iro_seed_loader #(
    parameter int N_STAGES = 25,
    parameter int DIV_W    = 8,
    parameter int RUN_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N_STAGES-1:0] seed_in,
    input  logic [DIV_W-1:0]    clk_div,
    input  logic [RUN_W-1:0]    run_cycles,
    input  logic [15:0]         phases_in,
    output logic                busy,
    output logic                done,
    output logic                bclk,
    output logic                bdat,
    output logic                enable,
    output logic [15:0]         phases_snap
);

    localparam int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_STAGES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_HIGH   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_RUN    = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t              state_r,   state_nxt_s;
    logic [DIV_W-1:0]    cnt_r,     cnt_nxt_s;
    logic [DIV_W-1:0]    div_r,     div_nxt_s;
    logic [RUN_W-1:0]    run_r,     run_nxt_s;
    logic [RUN_W-1:0]    run_cnt_r, run_cnt_nxt_s;
    logic [IDX_W-1:0]    idx_r,     idx_nxt_s;
    logic [N_STAGES-1:0] shreg_r,   shreg_nxt_s;
    logic [15:0]         sync1_r,   sync2_r;
    logic                capture_s;
    logic                div_end_s;
    logic                busy_nxt_s, done_nxt_s, bclk_nxt_s, bdat_nxt_s, enable_nxt_s;

    // The divider counter runs 0..clk_div, so a phase lasts clk_div+1 cycles without needing an extra bit.
    assign div_end_s = (cnt_r == div_r);

    // Next-state, counter and shift-register update.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        div_nxt_s     = div_r;
        run_nxt_s     = run_r;
        run_cnt_nxt_s = run_cnt_r;
        idx_nxt_s     = idx_r;
        shreg_nxt_s   = shreg_r;
        capture_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_SETUP;
                    cnt_nxt_s   = {DIV_W{1'b0}};
                    div_nxt_s   = clk_div;
                    run_nxt_s   = run_cycles;
                    shreg_nxt_s = seed_in;
                    idx_nxt_s   = IDX_LAST;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (div_end_s) begin
                    cnt_nxt_s   = {DIV_W{1'b0}};
                    state_nxt_s = ST_HIGH;
                end else begin
                    cnt_nxt_s = cnt_r + DIV_ONE;
                end
            end
            ST_HIGH: begin
                if (div_end_s) begin
                    cnt_nxt_s = {DIV_W{1'b0}};
                    if (idx_r == {IDX_W{1'b0}}) begin
                        state_nxt_s = ST_SETTLE;
                    end else begin
                        idx_nxt_s   = idx_r - IDX_ONE;
                        shreg_nxt_s = shreg_r << 1;
                        state_nxt_s = ST_SETUP;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + DIV_ONE;
                end
            end
            ST_SETTLE: begin
                if (div_end_s) begin
                    cnt_nxt_s = {DIV_W{1'b0}};
                    if (run_r == {RUN_W{1'b0}}) begin
                        state_nxt_s = ST_DONE;
                        capture_s   = 1'b1;
                    end else begin
                        state_nxt_s   = ST_RUN;
                        run_cnt_nxt_s = run_r;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + DIV_ONE;
                end
            end
            ST_RUN: begin
                if (run_cnt_r == RUN_ONE) begin
                    state_nxt_s = ST_DONE;
                    capture_s   = 1'b1;
                end else begin
                    run_cnt_nxt_s = run_cnt_r - RUN_ONE;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up with the state register.
    always_comb begin
        busy_nxt_s   = (state_nxt_s != ST_IDLE);
        done_nxt_s   = (state_nxt_s == ST_DONE);
        bclk_nxt_s   = (state_nxt_s == ST_HIGH);
        enable_nxt_s = (state_nxt_s == ST_RUN);
        bdat_nxt_s   = ((state_nxt_s == ST_SETUP) || (state_nxt_s == ST_HIGH)) ?
                       shreg_nxt_s[N_STAGES-1] : 1'b0;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {DIV_W{1'b0}};
            div_r       <= {DIV_W{1'b0}};
            run_r       <= {RUN_W{1'b0}};
            run_cnt_r   <= {RUN_W{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            shreg_r     <= {N_STAGES{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
            bclk        <= 1'b0;
            bdat        <= 1'b0;
            enable      <= 1'b0;
            phases_snap <= 16'h0000;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            div_r       <= div_nxt_s;
            run_r       <= run_nxt_s;
            run_cnt_r   <= run_cnt_nxt_s;
            idx_r       <= idx_nxt_s;
            shreg_r     <= shreg_nxt_s;
            busy        <= busy_nxt_s;
            done        <= done_nxt_s;
            bclk        <= bclk_nxt_s;
            bdat        <= bdat_nxt_s;
            enable      <= enable_nxt_s;
            phases_snap <= capture_s ? sync2_r : phases_snap;
        end
    end

    // Two-flop synchroniser for the free-running oscillator phases.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 16'h0000;
            sync2_r <= 16'h0000;
        end else begin
            sync1_r <= phases_in;
            sync2_r <= sync1_r;
        end
    end

endmodule

// File: tb/tb_iro_seed_loader.sv
// Scoreboard bench for iro_seed_loader: the driver queues expected transactions,
// the monitor models the oscillator shift register and checks each done pulse.
module tb_iro_seed_loader;

    localparam int N = 25;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [N-1:0]  seed_in;
    logic [7:0]    clk_div;
    logic [15:0]   run_cycles;
    logic [15:0]   phases_in;
    logic          busy, done, bclk, bdat, enable;
    logic [15:0]   phases_snap;

    iro_seed_loader #(.N_STAGES(N), .DIV_W(8), .RUN_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .seed_in(seed_in), .clk_div(clk_div),
        .run_cycles(run_cycles), .phases_in(phases_in), .busy(busy), .done(done),
        .bclk(bclk), .bdat(bdat), .enable(enable), .phases_snap(phases_snap)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          t0;
        logic [N-1:0] seed;
        int          d;
        int          r;
        logic [15:0] snap;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, want);
    endtask

    task automatic push_exp(input int t0, input logic [N-1:0] s, input int d, input int r,
                            input logic [15:0] snap);
        exp_t e;
        e.t0 = t0; e.seed = s; e.d = d; e.r = r; e.snap = snap;
        q.push_back(e);
    endtask

    // Called at a negedge: presents a request sampled on the next posedge (cycle 0 = t0).
    task automatic issue(input logic [N-1:0] s, input logic [7:0] dv, input logic [15:0] rc,
                         output int t0);
        seed_in    = s;
        clk_div    = dv;
        run_cycles = rc;
        start      = 1'b1;
        t0         = cyc;
        push_exp(cyc, s, int'(dv) + 1, int'(rc), phases_in);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue", 64'(q.size()), 64'd0);
        q.delete();
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Monitor state
    logic [N-1:0] osc_r = '0;
    int  edge_cnt, en_cnt, busy_cnt, lo_len, hi_len, en_first, busy_start;
    bit  bad_phase, prev_bclk, prev_busy, post_done;
    logic [15:0] pend_snap;
    bit  pend_valid;

    initial begin
        exp_t e;
        int   blen;
        prev_bclk = 1'b0; prev_busy = 1'b0; post_done = 1'b0; pend_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (post_done) begin
                check("busy_after_done", 64'(busy), 64'd0);
                post_done = 1'b0;
            end
            if (pend_valid) begin
                check("snap_norun", 64'(phases_snap), 64'(pend_snap));
                pend_valid = 1'b0;
            end
            if (busy && !prev_busy) begin
                edge_cnt = 0; en_cnt = 0; busy_cnt = 0; lo_len = 0; hi_len = 0;
                en_first = -1; busy_start = cyc; bad_phase = 1'b0;
            end
            if (busy) busy_cnt++;
            if (bclk) begin
                if (!prev_bclk) begin
                    osc_r = {osc_r[N-2:0], bdat};
                    edge_cnt++;
                    if (q.size() > 0 && lo_len != q[0].d) bad_phase = 1'b1;
                    hi_len = 1;
                end else begin
                    hi_len++;
                end
            end else begin
                if (prev_bclk) begin
                    if (q.size() > 0 && hi_len != q[0].d) bad_phase = 1'b1;
                    lo_len = 1;
                end else begin
                    lo_len++;
                end
            end
            if (enable) begin
                en_cnt++;
                if (en_first < 0) en_first = cyc;
            end
            if (done) begin
                check("done_expected", 64'(q.size() > 0), 64'd1);
                if (q.size() > 0) begin
                    e    = q.pop_front();
                    blen = 2 * N * e.d + e.d + e.r + 1;
                    check("done_cycle", 64'(cyc), 64'(e.t0 + blen));
                    check("busy_start", 64'(busy_start), 64'(e.t0 + 1));
                    check("busy_len", 64'(busy_cnt), 64'(blen));
                    check("bclk_edges", 64'(edge_cnt), 64'(N));
                    check("osc_seed", 64'(osc_r), 64'(e.seed));
                    check("phase_len", 64'(bad_phase), 64'd0);
                    check("enable_cycles", 64'(en_cnt), 64'(e.r));
                    if (e.r > 0) begin
                        check("enable_first", 64'(en_first), 64'(e.t0 + 2 * N * e.d + e.d + 1));
                        check("snap_run", 64'(phases_snap), 64'(e.snap));
                    end else begin
                        pend_valid = 1'b1;
                        pend_snap  = e.snap;
                    end
                end
                post_done = 1'b1;
            end
            prev_bclk = bclk;
            prev_busy = busy;
        end
    end

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, ta, tb, blen_a;
        rst = 1'b1; start = 1'b0; seed_in = '0; clk_div = 8'd0; run_cycles = 16'd0;
        phases_in = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({busy, done, bclk, bdat, enable, phases_snap}), 64'd0);
        rst = 1'b0;
        phases_in = 16'h1234;
        repeat (4) @(negedge clk);

        // Fastest load, no run
        issue(25'h1555555, 8'd0, 16'd0, t0);
        @(negedge clk) start = 1'b0;
        drain(200);
        repeat (3) @(negedge clk);

        // Reset mid-SETUP (clk_div=5): transaction aborted, nothing expected
        seed_in = 25'h1555555; clk_div = 8'd5; run_cycles = 16'd0; start = 1'b1;
        t0 = cyc;
        @(negedge clk) start = 1'b0;
        wait_cyc(t0 + 3);
        check("pre_reset_busy_bdat", 64'({busy, bdat, bclk}), 64'b110);
        rst = 1'b1;
        @(negedge clk);
        check("mid_reset_outputs", 64'({busy, done, bclk, bdat, enable, phases_snap}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_outputs", 64'({busy, done, bclk, bdat, enable, phases_snap}), 64'd0);

        // Divider: 4-cycle phases
        phases_in = 16'h00FF;
        repeat (3) @(negedge clk);
        issue(25'h0000001, 8'd3, 16'd0, t0);
        @(negedge clk) start = 1'b0;
        drain(400);
        repeat (3) @(negedge clk);

        // Run and capture
        phases_in = 16'hA5C3;
        repeat (3) @(negedge clk);
        issue(25'h1ABCDEF, 8'd0, 16'd10, t0);
        @(negedge clk) start = 1'b0;
        drain(200);
        repeat (3) @(negedge clk);

        // Start pulses mid-transaction are ignored
        phases_in = 16'h5A5A;
        repeat (3) @(negedge clk);
        issue(25'h0123456, 8'd0, 16'd0, t0);
        @(negedge clk) start = 1'b0;
        wait_cyc(t0 + 5);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_cyc(t0 + 30);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        drain(200);
        repeat (80) @(negedge clk);

        // Start held high: back-to-back with seed resampled
        issue(25'h1F0F0F0, 8'd0, 16'd2, ta);
        blen_a = 2 * N + 1 + 2 + 1;
        tb = ta + blen_a + 1;
        push_exp(tb, 25'h0ABCDEF, 1, 2, phases_in);
        wait_cyc(ta + 10);
        seed_in = 25'h0ABCDEF;
        wait_cyc(tb + 1);
        start = 1'b0;
        drain(300);
        repeat (3) @(negedge clk);

        // Max divider and run length
        phases_in = 16'hC3C3;
        repeat (3) @(negedge clk);
        issue(25'h1000001, 8'hFF, 16'hFFFF, t0);
        @(negedge clk) start = 1'b0;
        drain(80000);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
